// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB full-speed packet transmitter with NRZI encoding, bit stuffing and CRC16.
// Sends SYNC, PID, optional payload + CRC16, then EOP; four clocks per bit time.
module usb_tx_ctrl (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [2:0] tx_pid,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       tx_done
);
    typedef enum logic [3:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J, DONE} state_t;
    state_t      state, nxt;
    logic [1:0]  timer;
    logic [2:0]  ones, ones_n, bit_cnt, pid;
    logic [7:0]  shift, nbyte, pid_byte;
    logic [6:0]  rem;
    logic [15:0] crc, crc_upd, crc_n;
    logic [3:0]  p4;
    logic        stuff, bnd, in_bits, byte_end, pop, is_data, req_data, req_hs, accept, fb, sym;
    always_comb begin
        req_data = tx_pid == 3'b011 || tx_pid == 3'b100;
        req_hs   = tx_pid == 3'b101 || tx_pid == 3'b111 || tx_pid == 3'b000;
        accept   = tx_start && (req_hs || (req_data && buffer_occupancy <= 7'd64));
        is_data  = pid == 3'b011 || pid == 3'b100;
        p4 = pid == 3'b011 ? 4'b0011 : pid == 3'b100 ? 4'b1011 : pid == 3'b101 ? 4'b0010 :
             pid == 3'b111 ? 4'b1010 : 4'b1110;
        pid_byte = {~p4, p4};
        bnd      = timer == 2'd3;
        in_bits  = state == SYNC || state == PID || state == DATA || state == CRC_LO || state == CRC_HI;
        byte_end = bnd && in_bits && !stuff && bit_cnt == 3'd7;
        pop      = byte_end && rem != 7'd0 && ((state == PID && is_data) || state == DATA);
        ones_n   = shift[0] ? ones + 3'd1 : 3'd0;
        // reflected form of x^16+x^15+x^2+1, LSB-first bit order
        fb       = crc[0] ^ shift[0];
        crc_upd  = {1'b0, crc[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
        crc_n    = state == DATA ? crc_upd : crc;
        nxt = state == SYNC ? PID : state == CRC_LO ? CRC_HI : state == CRC_HI ? EOP_SE0 :
              (state == PID && !is_data) ? EOP_SE0 : pop ? DATA : CRC_LO;
        nbyte = nxt == PID ? pid_byte : nxt == DATA ? tx_packet_data : nxt == CRC_LO ? ~crc_n[7:0] :
                nxt == CRC_HI ? ~crc[15:8] : 8'h00;
        sym = byte_end ? nbyte[0] : shift[1];
    end
    assign get_tx_packet_data = pop;
    assign tx_transfer_active = state != IDLE;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            timer      <= 2'd0;
            ones       <= 3'd0;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            rem        <= 7'd0;
            pid        <= 3'd0;
            crc        <= 16'hFFFF;
            stuff      <= 1'b0;
            dplus_out  <= 1'b1;
            dminus_out <= 1'b0;
            tx_error   <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_error <= 1'b0;
            tx_done  <= 1'b0;
            timer    <= (state == IDLE || state == DONE) ? 2'd0 : timer + 2'd1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SYNC;
                        pid        <= tx_pid;
                        rem        <= buffer_occupancy;
                        shift      <= 8'h80;
                        bit_cnt    <= 3'd0;
                        ones       <= 3'd0;
                        stuff      <= 1'b0;
                        crc        <= 16'hFFFF;
                        dplus_out  <= ~dplus_out;
                        dminus_out <= ~dminus_out;
                    end else if (tx_start) begin
                        tx_error <= 1'b1;
                    end
                end
                SYNC, PID, DATA, CRC_LO, CRC_HI: begin
                    if (bnd && stuff) begin
                        stuff <= 1'b0;
                        if (!shift[0]) begin
                            dplus_out  <= ~dplus_out;
                            dminus_out <= ~dminus_out;
                        end
                    end else if (bnd) begin
                        crc     <= crc_n;
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= byte_end ? nbyte : {1'b0, shift[7:1]};
                        if (byte_end)
                            state <= nxt;
                        if (pop)
                            rem <= rem - 7'd1;
                        // a stuff bit may follow the last CRC bit even though the state is already EOP
                        if (ones_n == 3'd6) begin
                            stuff      <= 1'b1;
                            ones       <= 3'd0;
                            dplus_out  <= ~dplus_out;
                            dminus_out <= ~dminus_out;
                        end else begin
                            ones <= ones_n;
                            if (byte_end && nxt == EOP_SE0) begin
                                dplus_out  <= 1'b0;
                                dminus_out <= 1'b0;
                            end else if (!sym) begin
                                dplus_out  <= ~dplus_out;
                                dminus_out <= ~dminus_out;
                            end
                        end
                    end
                end
                EOP_SE0: begin
                    if (bnd && stuff) begin
                        stuff      <= 1'b0;
                        dplus_out  <= 1'b0;
                        dminus_out <= 1'b0;
                    end else if (bnd && bit_cnt == 3'd1) begin
                        state      <= EOP_J;
                        bit_cnt    <= 3'd0;
                        dplus_out  <= 1'b1;
                        dminus_out <= 1'b0;
                    end else if (bnd) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                EOP_J: begin
                    if (bnd) begin
                        state   <= DONE;
                        tx_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
